iram_isp_loader: RTL and testbench
==================================

Name: iram_isp_loader

Overview:
- AXI4-Lite write master that programs the instruction RAM during in-system programming (ISP).
- Sits upstream of the iram AXI4-Lite slave port. Consumes a byte stream (typically UART RX), packs bytes little-endian into 32-bit words, and writes them to consecutive word addresses.
- Boot code in the ISP region starts a session with a base address, then ends it with a flush.

Parameters:
- MAX_WORDS, 8192: maximum words written per session; reaching it ends the session.
- ADDR_W, 32: AXI byte-address width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  start session (honoured only in IDLE)
- base_addr_i  input  ADDR_W  session start byte address; bits [1:0] ignored
- flush_i  input  1  end session; pending partial word is written
- byte_i  input  8  stream byte
- byte_vld_i  input  1  byte valid
- byte_rdy_o  output  1  byte ready
- busy_o  output  1  session active
- done_o  output  1  one-cycle pulse at session end
- err_o  output  1  sticky: non-OKAY bresp seen; cleared by start_i
- word_cnt_o  output  clog2(MAX_WORDS+1)  words completed this session
- m_axi_awaddr/awprot/awvalid/awready  output/output/output/input  ADDR_W/3/1/1  AW channel; awprot=0
- m_axi_wdata/wstrb/wvalid/wready  output/output/output/input  32/4/1/1  W channel
- m_axi_bresp/bvalid/bready  input/input/output  2/1/1  B channel
- chk_o  output  32  running checksum (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset: all outputs 0; state IDLE; internal address, byte lane, strobes, flush flag and counters cleared. Reset mid-transaction abandons it; no further AXI activity until the next start_i.
- State IDLE:
  - byte_rdy_o=0, busy_o=0.
  - start_i: addr<={base_addr_i[ADDR_W-1:2],2'b00}; lane=0; strobes=0; word_cnt=0; err cleared; chk=0; go to COLLECT.
  - flush_i alone in IDLE: ignored.
- State COLLECT:
  - busy_o=1, byte_rdy_o=1.
  - Byte handshake (vld&rdy): wdata[8*lane+:8]<=byte_i; wstrb[lane]<=1; lane++.
  - Accepting lane 3 -> WRITE next cycle.
  - flush_i: set the flush flag. If a byte is accepted in the same cycle, the byte is taken first.
  - After flush, if strobes are nonzero: -> WRITE with the partial wstrb (e.g. 4'b0011). If strobes are zero: -> DONE.
  - start_i while busy: ignored.
- State WRITE:
  - byte_rdy_o=0. Assert awvalid and wvalid together in the first WRITE cycle.
  - Each valid holds stable until its own ready is seen, then drops independently.
  - Transition to RESP once both handshakes have completed, whether in the same cycle or different cycles.
  - Same-cycle completion of both handshakes (the normal iram case) gives 1 WRITE cycle.
- State RESP:
  - bready=1 in RESP only.
  - On bvalid: err|=(bresp!=0); addr+=4 (wraps modulo 2^ADDR_W); word_cnt++; lane=0; strobes=0; wdata=0.
  - Next: DONE if flush flag is set or word_cnt becomes MAX_WORDS; else COLLECT.
- State DONE: done_o=1 for one cycle; busy_o=0; -> IDLE. word_cnt_o and err_o are held until the next start_i.
- Latency: last byte accepted -> awvalid 1 cycle later. Minimum 4-byte word cost with an always-ready slave:
  - 4 COLLECT cycles
  - 1 WRITE cycle
  - 1 RESP cycle (bvalid tied high)
- Throughput: 1 word per 6 cycles at minimum.
- Boundaries:
  - Stream stalls (byte_vld_i=0) are tolerated indefinitely.
  - At MAX_WORDS, no further bytes are accepted.
  - bvalid outside RESP is ignored.

Optional Feature:
- Macro: ISP_CHECKSUM_EN.
- Defined: chk_o is a 32-bit wrapping sum of every written wdata, masked by its wstrb (unwritten lanes count as 0). It updates on the bvalid accept and is cleared by start_i.
- Undefined: chk_o is tied to 32'h0 and no adder logic is present.

Test Plan:
- start_i, base 0x0000_0100; bytes 11 22 33 44 55 66 77 88; flush -> writes 0x100=0x44332211 and 0x104=0x88776655, both wstrb=F; word_cnt_o=2; done_o pulses once.
- Bytes AA BB then flush -> one write, wdata=0x0000BBAA, wstrb=4'b0011; word_cnt_o=1.
- Slave wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until it completes; exactly one write issued.
- bresp=2'b10 on the first word -> err_o=1 and stays 1 through done; the next start_i clears it.
- MAX_WORDS=2 with 12 bytes offered -> 2 writes, done_o pulses, byte_rdy_o=0 for the remaining 4 bytes.
- ISP_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x00000002 -> chk_o=0x00000001. Undefined -> chk_o=0.
- rst_n pulled low during WRITE -> awvalid=wvalid=0 asynchronously, state IDLE, word_cnt_o=0.

Source files
------------

// File: rtl/iram_isp_loader.sv
// ---------------------------------------------------------------------------
// iram_isp_loader
// AXI4-Lite write master used during in-system programming. Packs a byte
// stream little-endian into 32-bit words and writes them to consecutive
// word addresses of the instruction RAM, starting at a session base address.
// A session ends on flush (a pending partial word is written with a partial
// strobe) or when MAX_WORDS words have been written.
//
// Optional build macro: ISP_CHECKSUM_EN
//   defined   -> chk_o is a wrapping 32-bit sum of every written word,
//                masked by its strobe, updated on each accepted B response.
//   undefined -> chk_o is tied to zero.
// ---------------------------------------------------------------------------
module iram_isp_loader #(
    parameter int MAX_WORDS = 8192,
    parameter int ADDR_W    = 32,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              flush_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_vld_i,
    output logic              byte_rdy_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [31:0]       chk_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        lane;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              flush_flag;
    logic [CNT_W-1:0]  word_cnt;
    logic              err;
    logic              awvalid;
    logic              wvalid;

    logic              byte_fire;
    logic [3:0]        strb_next;
    logic              aw_ok;
    logic              w_ok;
    logic              b_fire;
    logic [CNT_W-1:0]  cnt_inc;

    // Word alignment drops the two low base-address bits.
    logic unused_base_lsbs;
    assign unused_base_lsbs = &{1'b0, base_addr_i[1:0]};

    assign byte_fire = (state == S_COLLECT) && byte_vld_i;
    // Strobes as they will be after this cycle's byte, so a flush arriving
    // together with a byte sees that byte as already collected.
    assign strb_next = wstrb | (byte_fire ? (4'b0001 << lane) : 4'b0000);
    // A channel is finished once its valid has dropped or is being accepted.
    assign aw_ok     = !awvalid || m_axi_awready;
    assign w_ok      = !wvalid  || m_axi_wready;
    assign b_fire    = (state == S_RESP) && m_axi_bvalid;
    assign cnt_inc   = word_cnt + CNT_W'(1);

    // Session FSM, byte packing and AXI write sequencing.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            lane       <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            flush_flag <= 1'b0;
            word_cnt   <= '0;
            err        <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        addr       <= {base_addr_i[ADDR_W-1:2], 2'b00};
                        lane       <= '0;
                        wdata      <= '0;
                        wstrb      <= '0;
                        flush_flag <= 1'b0;
                        word_cnt   <= '0;
                        err        <= 1'b0;
                        state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (byte_fire) begin
                        wdata[8*lane +: 8] <= byte_i;
                        wstrb              <= strb_next;
                        lane               <= lane + 2'd1;
                    end
                    if (flush_i) begin
                        flush_flag <= 1'b1;
                    end
                    if (byte_fire && (lane == 2'd3)) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= S_WRITE;
                    end else if (flush_flag || flush_i) begin
                        if (strb_next != 4'b0000) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_WRITE;
                        end else begin
                            state   <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (awvalid && m_axi_awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && m_axi_wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (b_fire) begin
                        err      <= err | (m_axi_bresp != 2'b00);
                        addr     <= addr + ADDR_W'(4);
                        word_cnt <= cnt_inc;
                        lane     <= '0;
                        wstrb    <= '0;
                        wdata    <= '0;
                        if (flush_flag || (cnt_inc == MAX_CNT)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ISP_CHECKSUM_EN
    logic [31:0] chk;
    logic [31:0] strb_mask;

    assign strb_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

    // Running checksum of written words, restarted with each session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk <= '0;
        end else if ((state == S_IDLE) && start_i) begin
            chk <= '0;
        end else if (b_fire) begin
            chk <= chk + (wdata & strb_mask);
        end
    end

    assign chk_o = chk;
`else
    assign chk_o = 32'h0;
`endif

    assign byte_rdy_o    = (state == S_COLLECT);
    assign busy_o        = (state == S_COLLECT) || (state == S_WRITE) || (state == S_RESP);
    assign done_o        = (state == S_DONE);
    assign err_o         = err;
    assign word_cnt_o    = word_cnt;
    assign m_axi_awaddr  = addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = wstrb;
    assign m_axi_wvalid  = wvalid;
    assign m_axi_bready  = (state == S_RESP);

endmodule

// File: tb/tb_iram_isp_loader.sv
// ---------------------------------------------------------------------------
// tb_iram_isp_loader
// Directed bench for iram_isp_loader. Each session's expected writes are
// derived from the byte list by little-endian grouping; a monitor compares
// every AXI handshake, counter, error flag and checksum against that model
// each cycle. Honours ISP_CHECKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_iram_isp_loader;

    localparam int TB_MAX = 4;
    localparam int CNT_W  = $clog2(TB_MAX + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [31:0]      base_addr_i;
    logic             flush_i;
    logic [7:0]       byte_i;
    logic             byte_vld_i;
    logic             byte_rdy_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] word_cnt_o;
    logic [31:0]      m_axi_awaddr;
    logic [2:0]       m_axi_awprot;
    logic             m_axi_awvalid;
    logic             m_axi_awready;
    logic [31:0]      m_axi_wdata;
    logic [3:0]       m_axi_wstrb;
    logic             m_axi_wvalid;
    logic             m_axi_wready;
    logic [1:0]       m_axi_bresp;
    logic             m_axi_bvalid;
    logic             m_axi_bready;
    logic [31:0]      chk_o;

    int checks = 0;
    int errors = 0;

    // Model state
    wr_t         exp_q[$];
    wr_t         log_q[$];
    logic [7:0]  stim[$];
    int          mdl_cnt = 0;
    logic        mdl_err = 1'b0;
    logic [31:0] mdl_chk = '0;
    int          done_cnt = 0;
    int          bytes_acc = 0;
    int          aw_hi = 0;
    int          w_hi = 0;
    bit          aw_seen = 0;
    bit          w_seen = 0;
    logic [31:0] act_addr;
    logic [31:0] act_data;
    logic [3:0]  act_strb;
    bit          prev_aw = 0;
    bit          prev_w = 0;
    bit          prev_done = 0;
    logic [31:0] prev_awaddr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;

    // Slave configuration
    int aw_lat = 0;
    int w_lat = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int err_word = -1;

    iram_isp_loader #(.MAX_WORDS(TB_MAX), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .flush_i(flush_i), .byte_i(byte_i), .byte_vld_i(byte_vld_i),
        .byte_rdy_o(byte_rdy_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .word_cnt_o(word_cnt_o), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .chk_o(chk_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    // Expected writes: bytes grouped four at a time, little-endian, at
    // consecutive word addresses, truncated at the session word limit.
    task automatic build_expect(input logic [31:0] base);
        int  n;
        int  nw;
        wr_t w;
        n  = stim.size();
        nw = (n + 3) / 4;
        if (nw > TB_MAX) nw = TB_MAX;
        for (int i = 0; i < nw; i++) begin
            w.addr = {base[31:2], 2'b00} + 32'(4 * i);
            w.data = '0;
            w.strb = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < n) begin
                    w.data[8*k +: 8] = stim[4*i + k];
                    w.strb[k]        = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
    endtask

    // Simple slave: readies after a configurable wait, bvalid always high
    // (also exercises bvalid outside RESP), error response on one word.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            aw_cnt = 0;
            w_cnt  = 0;
        end else begin
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_cnt >= aw_lat);
                aw_cnt++;
            end else begin
                m_axi_awready = 1'b0;
                aw_cnt = 0;
            end
            if (m_axi_wvalid) begin
                m_axi_wready = (w_cnt >= w_lat);
                w_cnt++;
            end else begin
                m_axi_wready = 1'b0;
                w_cnt = 0;
            end
            m_axi_bresp = (mdl_cnt == err_word) ? 2'b10 : 2'b00;
        end
    end

    // Compare process: checks outputs against the model each cycle, then
    // advances the model with the handshakes seen in this cycle.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            mdl_cnt = 0;
            mdl_err = 1'b0;
            mdl_chk = '0;
            aw_seen = 0;
            w_seen = 0;
            prev_aw = 0;
            prev_w = 0;
            prev_done = 0;
        end else begin
            check("word_cnt", 64'(word_cnt_o), 64'(mdl_cnt));
            check("err", 64'(err_o), 64'(mdl_err));
`ifdef ISP_CHECKSUM_EN
            check("chk", 64'(chk_o), 64'(mdl_chk));
`else
            check("chk", 64'(chk_o), 64'(0));
`endif
            check("done_one_cycle", 64'(done_o & prev_done), 64'(0));
            check("rdy_implies_busy", 64'(byte_rdy_o & ~busy_o), 64'(0));
            if (prev_aw) begin
                check("awvalid_hold", 64'(m_axi_awvalid), 64'(1));
                check("awaddr_hold", 64'(m_axi_awaddr), 64'(prev_awaddr));
            end
            if (prev_w) begin
                check("wvalid_hold", 64'(m_axi_wvalid), 64'(1));
                check("wdata_hold", 64'({m_axi_wstrb, m_axi_wdata}), 64'({prev_wstrb, prev_wdata}));
            end
            if (m_axi_awvalid) check("awprot", 64'(m_axi_awprot), 64'(0));

            if (start_i && !busy_o && !done_o) begin
                mdl_cnt = 0;
                mdl_err = 1'b0;
                mdl_chk = '0;
            end
            if (done_o) done_cnt++;
            if (byte_vld_i && byte_rdy_o) bytes_acc++;
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid) w_hi++;
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_q.size() == 0) begin
                    check("aw_unexpected", 64'(1), 64'(0));
                end else begin
                    check("awaddr", 64'(m_axi_awaddr), 64'(exp_q[0].addr));
                    act_addr = m_axi_awaddr;
                    aw_seen = 1;
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_q.size() == 0) begin
                    check("w_unexpected", 64'(1), 64'(0));
                end else begin
                    check("wdata", 64'(m_axi_wdata), 64'(exp_q[0].data));
                    check("wstrb", 64'(m_axi_wstrb), 64'(exp_q[0].strb));
                    act_data = m_axi_wdata;
                    act_strb = m_axi_wstrb;
                    w_seen = 1;
                end
            end
            if (m_axi_bready && m_axi_bvalid) begin
                check("b_after_aw_w", 64'(aw_seen && w_seen), 64'(1));
                if (exp_q.size() != 0) begin
                    mdl_cnt++;
                    mdl_err = mdl_err | (m_axi_bresp != 2'b00);
                    mdl_chk = mdl_chk + (exp_q[0].data & lane_mask(exp_q[0].strb));
                    log_q.push_back('{addr: act_addr, data: act_data, strb: act_strb});
                    void'(exp_q.pop_front());
                end
                aw_seen = 0;
                w_seen = 0;
            end
            prev_aw     = m_axi_awvalid && !m_axi_awready;
            prev_w      = m_axi_wvalid && !m_axi_wready;
            prev_awaddr = m_axi_awaddr;
            prev_wdata  = m_axi_wdata;
            prev_wstrb  = m_axi_wstrb;
            prev_done   = done_o;
        end
    end

    task automatic do_start(input logic [31:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_i     = b;
        byte_vld_i = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (byte_rdy_o) ok = 1;
            @(negedge clk);
        end
        byte_vld_i = 1'b0;
        if (!ok) check("byte_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!byte_rdy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!byte_rdy_o) check("rdy_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_flush();
        wait_rdy();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt);
        int t = 0;
        while (done_cnt == base_cnt && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == base_cnt) check("done_timeout", 64'(0), 64'(1));
        repeat (2) @(negedge clk);
        check("done_once", 64'(done_cnt - base_cnt), 64'(1));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
    endtask

    // Complete session: expectations, start, bytes, optional flush, done.
    task automatic run_session(input logic [31:0] base, input bit flush);
        int d0;
        log_q.delete();
        build_expect(base);
        d0 = done_cnt;
        do_start(base);
        foreach (stim[i]) send_byte(stim[i]);
        if (flush) do_flush();
        wait_done(d0);
    endtask

    initial begin
        int acc0;
        rst_n = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        flush_i = 1'b0;
        byte_i = '0;
        byte_vld_i = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp = 2'b00;
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
        check("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
        check("rst_busy_rdy_done", 64'({busy_o, byte_rdy_o, done_o, m_axi_bready}), 64'(0));
        check("rst_cnt_err_chk", 64'({word_cnt_o, err_o, chk_o}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Two full words then flush with nothing pending.
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_session(32'h0000_0100, 1'b1);
        check("t1_writes", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            check("t1_w0", 64'({log_q[0].addr, log_q[0].data}), 64'h0000_0100_4433_2211);
            check("t1_w1", 64'({log_q[1].addr, log_q[1].data}), 64'h0000_0104_8877_6655);
            check("t1_strb", 64'({log_q[0].strb, log_q[1].strb}), 64'hFF);
        end
        check("t1_word_cnt", 64'(word_cnt_o), 64'(2));

        // Partial word, unaligned base, start ignored while busy.
        stim = '{8'hAA, 8'hBB};
        log_q.delete();
        build_expect(32'h0000_0203);
        acc0 = done_cnt;
        do_start(32'h0000_0203);
        send_byte(8'hAA);
        do_start(32'h0000_0800);
        send_byte(8'hBB);
        do_flush();
        wait_done(acc0);
        check("t2_writes", 64'(log_q.size()), 64'(1));
        if (log_q.size() == 1) begin
            check("t2_w0", 64'({log_q[0].addr, log_q[0].data}), 64'h0000_0200_0000_BBAA);
            check("t2_strb", 64'(log_q[0].strb), 64'h3);
        end
        check("t2_word_cnt", 64'(word_cnt_o), 64'(1));

        // W channel accepted three cycles after AW.
        aw_lat = 0;
        w_lat  = 3;
        aw_hi  = 0;
        w_hi   = 0;
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(32'h0000_1000, 1'b1);
        check("t3_aw_cycles", 64'(aw_hi), 64'(1));
        check("t3_w_cycles", 64'(w_hi), 64'(4));
        check("t3_writes", 64'(log_q.size()), 64'(1));
        w_lat = 0;

        // Error response on the first word stays sticky through done.
        err_word = 0;
        stim = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        run_session(32'h0000_2000, 1'b1);
        err_word = -1;
        check("t4_err_sticky", 64'(err_o), 64'(1));
        check("t4_writes", 64'(log_q.size()), 64'(2));

        // Checksum of 0xFFFFFFFF + 0x00000002; start also clears err.
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        log_q.delete();
        build_expect(32'h0000_3000);
        acc0 = done_cnt;
        do_start(32'h0000_3000);
        check("t5_err_cleared", 64'(err_o), 64'(0));
        foreach (stim[i]) send_byte(stim[i]);
        do_flush();
        wait_done(acc0);
`ifdef ISP_CHECKSUM_EN
        check("t5_chk", 64'(chk_o), 64'h0000_0001);
`else
        check("t5_chk", 64'(chk_o), 64'h0000_0000);
`endif

        // Word limit: session ends by itself, further bytes refused.
        stim.delete();
        for (int i = 0; i < 4 * TB_MAX; i++) stim.push_back(8'(8'hC0 + i));
        run_session(32'h0000_4000, 1'b0);
        check("t6_writes", 64'(log_q.size()), 64'(TB_MAX));
        if (log_q.size() == TB_MAX)
            check("t6_last", 64'({log_q[TB_MAX-1].addr, log_q[TB_MAX-1].data}), 64'h0000_400C_CFCE_CDCC);
        check("t6_word_cnt", 64'(word_cnt_o), 64'(TB_MAX));
        acc0 = bytes_acc;
        byte_vld_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_i = 8'(8'hE0 + i);
            check("t6_rdy_low", 64'(byte_rdy_o), 64'(0));
            @(negedge clk);
        end
        byte_vld_i = 1'b0;
        check("t6_no_extra", 64'(bytes_acc - acc0), 64'(0));

        // Reset asserted while a write is outstanding.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        log_q.delete();
        build_expect(32'h0000_5000);
        do_start(32'h0000_5000);
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        wait_rdy();
        aw_lat = 6;
        w_lat  = 6;
        for (int i = 4; i < 8; i++) send_byte(stim[i]);
        for (int t = 0; t < 50 && !m_axi_awvalid; t++) @(negedge clk);
        check("t7_in_write", 64'({m_axi_awvalid, m_axi_wvalid}), 64'h3);
        check("t7_cnt_before", 64'(word_cnt_o), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_valids_async", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(0));
        check("t7_idle", 64'({busy_o, byte_rdy_o, m_axi_bready}), 64'(0));
        check("t7_cnt_cleared", 64'(word_cnt_o), 64'(0));
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        aw_lat = 0;
        w_lat  = 0;
        repeat (6) @(negedge clk);
        check("t7_no_axi", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
